// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide controller holding the architectural HI/LO
//   registers of a 5-stage MIPS pipeline. One shift-add (multiply) or
//   restoring-divide step is done per cycle over WIDTH cycles, followed by a
//   sign-fix cycle that writes HI/LO.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start, op      mult(00)/multu(01)/div(10)/divu(11) issued from EX
//   a, b           rs / rt operands
//   flush          EX instruction cancelled; blocks acceptance of start
//   hi_we, lo_we   mthi / mtlo write enables, data on wdata
//   rd_req         mfhi/mflo in ID needs HI/LO
//   hi, lo         architectural HI/LO registers
//   busy           sequence in progress (RUN or FIX)
//   stall          hazard request while busy and HI/LO or the unit is needed
//   done           one-cycle pulse on the cycle HI/LO take a new result
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic               ovf;

  logic               sgn_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   most_neg;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   q_val;
  logic [WIDTH-1:0]   r_val;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign stall = busy && (start || rd_req || hi_we || lo_we);

  always_comb begin
    most_neg = '0;
    most_neg[WIDTH-1] = 1'b1;
    sgn_op = ~op[0];
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    mag_a  = a_neg ? (WIDTH'(0) - a) : a;
    mag_b  = b_neg ? (WIDTH'(0) - b) : b;
  end

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : WIDTH'(0))};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring-divide step. The (WIDTH+1)-bit shifted remainder is split into
  // its top bit and the low WIDTH bits: when the top bit is set the trial
  // subtraction always succeeds, and the true difference then fits WIDTH bits.
  always_comb begin
    div_sh   = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    div_ge   = acc[2*WIDTH-1] | (div_sh >= opnd);
    div_diff = div_sh - opnd;
    div_next = {(div_ge ? div_diff : div_sh), acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod_neg = (2*WIDTH)'(0) - acc;
    q_val    = acc[WIDTH-1:0];
    r_val    = acc[2*WIDTH-1:WIDTH];
    res_hi   = '0;
    res_lo   = '0;
    if (!is_div) begin
      {res_hi, res_lo} = neg_q ? prod_neg : acc;
    end else if (div_zero) begin
      res_lo = '1;
      res_hi = a_raw;
    end else if (ovf) begin
      res_lo = most_neg;
      res_hi = '0;
    end else begin
      res_lo = neg_q ? (WIDTH'(0) - q_val) : q_val;
      res_hi = neg_r ? (WIDTH'(0) - r_val) : r_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            a_raw    <= a;
            div_zero <= op[1] && (b == '0);
            ovf      <= (op == 2'b10) && (a == most_neg) && (b == '1);
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer (WIDTH=32): a vector table of
//   mult/div operations with expected HI/LO, a scoreboard queue of expected
//   results, and hand-written sequences for stall, flush, mtlo-while-busy and
//   mid-sequence reset.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         rd_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  vec_t vecs[13];
  logic [2*W-1:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back({eh, el});
  endtask

  // Waits for done with a cycle bound; optionally pulses flush mid-run.
  task automatic wait_result(input string name, input bit flush_mid);
    int cyc;
    bit got;
    logic [2*W-1:0] exp;
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1;
      flush = (flush_mid && cyc == 5);
    end
    flush = 1'b0;
    check({name, "_latency"}, W'(cyc), W'(33));
    if (got) begin
      if (sb_q.size() == 0) begin
        check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check({name, "_hi"}, hi, exp[2*W-1:W]);
        check({name, "_lo"}, lo, exp[W-1:0]);
        check({name, "_busy_after"}, W'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit got;
    logic [2*W-1:0] exp;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'd7,        32'h00000006, 32'hFFFFFFF9};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[7]  = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[10] = '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
    vecs[11] = '{2'b10, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000};
    vecs[12] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_stall", W'(stall), '0);
    check("rst_done", W'(done), '0);

    // mthi + mtlo in the same cycle, then mtlo alone
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'hA5A5A5A5);
    check("mt_both_lo", lo, 32'hA5A5A5A5);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5555;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_hi_kept", hi, 32'hA5A5A5A5);
    check("mtlo_lo", lo, 32'h5555);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
      check($sformatf("v%0d_busy_start", i), W'(busy), 32'd1);
      wait_result($sformatf("v%0d", i), (i % 4) == 1);
    end

    // start with flush: not accepted, HI/LO untouched
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    check("flush_hi", hi, vecs[12].eh);
    check("flush_lo", lo, vecs[12].el);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("flush_no_done", W'(cnt), '0);

    // mult, then mfhi/mflo held in ID: stall until busy falls
    launch(2'b01, 32'd1000, 32'd3000, 32'd0, 32'd3000000);
    @(negedge clk);
    rd_req = 1'b1;
    got = 0;
    cnt = 0;
    while (!got && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!busy) got = 1;
      else check("rd_stall", W'(stall), 32'd1);
    end
    check("rd_release_cycle", W'(cnt), 32'd33);
    check("rd_unstall", W'(stall), '0);
    check("rd_done", W'(done), 32'd1);
    exp = sb_q.pop_front();
    check("rd_lo", lo, exp[W-1:0]);
    check("rd_hi", hi, exp[2*W-1:W]);
    @(negedge clk);
    rd_req = 1'b0;

    // mtlo while busy: stalled, dropped until IDLE, then taken on re-present
    launch(2'b00, 32'd3, 32'd5, 32'd0, 32'd15);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    got = 0;
    cnt = 0;
    while (!got && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) got = 1;
      else begin
        check("mtlo_busy_stall", W'(stall), 32'd1);
        check("mtlo_busy_lo", lo, 32'd3000000);
      end
    end
    exp = sb_q.pop_front();
    check("mtlo_result_lo", lo, exp[W-1:0]);
    check("mtlo_result_stall", W'(stall), '0);
    @(posedge clk);
    #1;
    check("mtlo_after_lo", lo, 32'h1234);
    lo_we = 1'b0;

    // start and mthi together in IDLE: start wins, write dropped
    launch(2'b11, 32'd50, 32'd7, 32'd1, 32'd7);
    wait_result("start_only", 1'b0);
    @(negedge clk);
    start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD; op = 2'b11; a = 32'd9; b = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    sb_q.push_back({32'd1, 32'd2});
    check("start_wins_hi", hi, 32'd1);
    wait_result("start_wins", 1'b0);

    // reset mid-RUN: abandon sequence, HI/LO cleared, no done
    launch(2'b00, 32'd11, 32'd13, 32'd0, 32'd143);
    void'(sb_q.pop_back());
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_done", W'(done), '0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", W'(cnt), '0);
    check("midrst_busy_end", W'(busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
